uart_tx_fifo: RTL and testbench

Byte queue and launch sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the system side on a single-cycle write strobe and buffers them in a DEPTH-entry FIFO. It hands the bytes to the transmitter one at a time using the transmitter's data/start/busy handshake. It keeps the next byte from launching until the transmitter has visibly started and then finished the current one.

---
 rtl/uart_tx_fifo_if.sv | 34 +++
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Bus bundle between the system side, the TX byte queue and the UART
// transmitter handshake.
//   wr_data/wr_en/flush : enqueue side (driven by system)
//   full/empty/count/overflow : queue status (driven by queue)
//   tx_data/tx_start/tx_err : launch side (driven by queue)
//   tx_busy : transmitter busy flag (driven by transmitter)
// master = system/transmitter side, slave = queue.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 16
) ();
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  wr_data;
  logic        wr_en;
  logic        flush;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_err;

  modport master (
    output wr_data, wr_en, flush, tx_busy,
    input  full, empty, count, overflow, tx_data, tx_start, tx_err
  );

  modport slave (
    input  wr_data, wr_en, flush, tx_busy,
    output full, empty, count, overflow, tx_data, tx_start, tx_err
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte queue and launch sequencer in front of a UART transmitter.
// Buffers up to DEPTH bytes and hands them out one at a time over the
// data/start/busy handshake, waiting for busy to rise and then fall before
// launching the next byte. A missing busy rise times out after
// BUSY_TIMEOUT cycles with a tx_err pulse; the byte is treated as consumed.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_fifo_if.slave (write side, status, transmitter handshake)
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 7
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [7:0]  TMO_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    LAUNCH  = 4'b0010,
    WAIT_HI = 4'b0100,
    WAIT_LO = 4'b1000
  } state_t;

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [7:0]    timer;
  logic [7:0]    tx_data_q;
  logic          tx_err_q;
  logic          full_w, empty_w;
  logic          push, pop, err_n;

  assign full_w  = (cnt == FULL_CNT);
  assign empty_w = (cnt == '0);
  // A write while full is rejected even if a pop frees a slot this cycle.
  assign push    = bus.wr_en & ~full_w & ~bus.flush;

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = cnt;
  assign bus.overflow = bus.wr_en & full_w & ~bus.flush;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = (state == LAUNCH);
  assign bus.tx_err   = tx_err_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      tx_data_q <= 8'h00;
      tx_err_q  <= 1'b0;
    end else begin
      state    <= state_n;
      tx_err_q <= err_n;
      // Zero in every other state, so it is already cleared on WAIT_HI entry.
      if (state == WAIT_HI) timer <= timer + 8'd1;
      else                  timer <= '0;
      if (pop) tx_data_q <= mem[rd_ptr];
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_w && !bus.flush) begin
          state_n = LAUNCH;
          pop     = 1'b1;
        end
      end
      LAUNCH:  state_n = WAIT_HI;
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_n = WAIT_LO;
        end else if (timer == TMO_LAST) begin
          // BUSY_TIMEOUT cycles spent here without busy; drop the byte.
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 7;

  logic clk = 1'b0;
  logic rst;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes as a queue plus the launch protocol phase.
  typedef enum int {FREE, STROBE, EXPECT_BUSY, IN_FRAME} phase_t;
  logic [7:0] pend_q[$];
  logic [7:0] sb_q[$];
  phase_t     ph = FREE;
  int         waited = 0;
  bit         err_exp = 0;
  logic [7:0] last_byte = 8'h00;
  int         cyc = 0;
  bit         take, go;
  int         n;

  int checks = 0, errors = 0;
  int ovf_cnt = 0, err_cnt = 0, start_cnt = 0, last_start_cyc = 0;

  // Transmitter stub controls
  bit stub_dead = 0;
  int len_min = 3, len_max = 3, rise_max = 2;
  int rise_cnt = 0, hold_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model update at each active edge, from the inputs present during the cycle.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend_q.delete();
      sb_q.delete();
      ph = FREE;
      waited = 0;
      err_exp = 0;
      last_byte = 8'h00;
    end else begin
      n    = pend_q.size();
      take = bus.wr_en && !bus.flush && (n < DEPTH);
      go   = (ph == FREE) && (n > 0) && !bus.flush;
      err_exp = 0;
      case (ph)
        FREE:        if (go) ph = STROBE;
        STROBE:      begin ph = EXPECT_BUSY; waited = 0; end
        EXPECT_BUSY: begin
          if (bus.tx_busy) ph = IN_FRAME;
          else begin
            waited++;
            if (waited == TMO) begin ph = FREE; err_exp = 1; end
          end
        end
        IN_FRAME:    if (!bus.tx_busy) ph = FREE;
        default:     ph = FREE;
      endcase
      if (bus.flush) pend_q.delete();
      else begin
        if (go) begin
          last_byte = pend_q.pop_front();
          sb_q.push_back(last_byte);
        end
        if (take) pend_q.push_back(bus.wr_data);
      end
    end
  end

  // Transmitter stub: busy rises some cycles after start, held for a frame.
  always @(posedge clk) begin
    #3;
    if (rst) begin
      bus.tx_busy = 1'b0;
      rise_cnt = 0;
      hold_cnt = 0;
    end else begin
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) bus.tx_busy = 1'b0;
      end
      if (rise_cnt > 0) begin
        rise_cnt--;
        if (rise_cnt == 0) begin
          bus.tx_busy = 1'b1;
          hold_cnt = $urandom_range(len_max, len_min);
        end
      end
      if (bus.tx_start === 1'b1 && !stub_dead)
        rise_cnt = (rise_max > 1) ? $urandom_range(rise_max, 1) : 1;
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the model and scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 32'(bus.count), 32'(pend_q.size()));
      chk("empty", 32'(bus.empty), 32'(pend_q.size() == 0));
      chk("full", 32'(bus.full), 32'(pend_q.size() == DEPTH));
      chk("overflow", 32'(bus.overflow),
          32'(bus.wr_en && !bus.flush && pend_q.size() == DEPTH));
      chk("tx_start", 32'(bus.tx_start), 32'(ph == STROBE));
      chk("tx_err", 32'(bus.tx_err), 32'(err_exp));
      chk("tx_data", 32'(bus.tx_data), 32'(last_byte));
      chk("start_while_busy", 32'(bus.tx_start & bus.tx_busy), 32'd0);
      if (bus.overflow === 1'b1) ovf_cnt++;
      if (bus.tx_err === 1'b1) err_cnt++;
      if (bus.tx_start === 1'b1) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (sb_q.size() == 0) chk("sb_unexpected_start", 32'd1, 32'd0);
        else chk("sb_byte", 32'(bus.tx_data), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic write_byte(input logic [7:0] d);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (ph == FREE && pend_q.size() == 0 && bus.tx_busy == 1'b0 && rise_cnt == 0) break;
      tick();
    end
    if (i == 3000) begin
      checks++;
      errors++;
      $display("FAIL %s: drain timed out, still pending %0d", name, pend_q.size());
    end
  endtask

  task automatic wait_busy(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      if (bus.tx_busy == 1'b1) break;
      tick();
    end
    if (i == 50) begin
      checks++;
      errors++;
      $display("FAIL %s: tx_busy never rose, got 0 required 1", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cyc, snap;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_empty", 32'(bus.empty), 32'd1);
    chk("reset_tx_data", 32'(bus.tx_data), 32'h00);

    // Single byte: tx_start in the cycle after edge N+1
    snap = start_cnt;
    write_byte(8'hA5);
    wr_cyc = cyc;
    drain("single");
    chk("single_starts", 32'(start_cnt - snap), 32'd1);
    chk("single_latency", 32'(last_start_cyc - wr_cyc), 32'd1);

    // Burst of 18 with long frames: 17 accepted, one overflow
    len_min = 20; len_max = 20; rise_max = 2;
    snap = ovf_cnt;
    for (int i = 1; i <= 18; i++) begin
      bus.wr_data = 8'(i);
      bus.wr_en = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    chk("burst_overflow_pulses", 32'(ovf_cnt - snap), 32'd1);
    snap = start_cnt;
    drain("burst");
    chk("burst_starts", 32'(start_cnt - snap), 32'd16);

    // Randomized traffic with short frames, occasional flush
    len_min = 1; len_max = 6; rise_max = 4;
    for (int i = 0; i < 400; i++) begin
      bus.wr_en   = ($urandom_range(99, 0) < 35);
      bus.wr_data = 8'($urandom);
      bus.flush   = ($urandom_range(149, 0) == 0);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    drain("random");

    // Flush while a frame is on the line, together with a write
    len_min = 20; len_max = 20; rise_max = 2;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 8'h30 + 8'(i);
      bus.wr_en = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    wait_busy("flush_wait");
    snap = start_cnt;
    bus.flush = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    chk("flush_count", 32'(bus.count), 32'd0);
    repeat (40) tick();
    chk("flush_no_start", 32'(start_cnt - snap), 32'd0);
    drain("flush");

    // Busy never rises: two timeouts, both bytes launched
    stub_dead = 1;
    snap = err_cnt;
    write_byte(8'h5A);
    write_byte(8'hC3);
    repeat (30) tick();
    chk("timeout_err_pulses", 32'(err_cnt - snap), 32'd2);
    stub_dead = 0;
    drain("timeout");

    // Reset in the middle of a frame
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    wait_busy("reset_wait");
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_err", 32'(bus.tx_err), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    tick();
    rst = 1'b0;
    snap = start_cnt;
    repeat (30) tick();
    chk("post_reset_no_start", 32'(start_cnt - snap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
